down_counter_timer: RTL
=======================

# down_counter_timer

Loadable down-counting timer: the counterpart to the free-running 8-bit up counter used for event counting in the design. It is loaded with a start value, started, and decrements once per enabled clock until it reaches zero. On reaching zero it pulses a terminal-count strobe and raises `done` until the consumer acknowledges. It sits beside the up counter as the timeout/interval source for control logic.

## Interface
- `WIDTH`, 8, width of the count and load value
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-low reset
- `load`  input  1  synchronous load and abort strobe
- `load_val`  input  WIDTH  start and reload value, sampled when `load`=1
- `start`  input  1  begin countdown, honoured only in IDLE
- `hold`  input  1  freeze the count while in RUN
- `ack`  input  1  consumer acknowledge of `done`, honoured only in DONE
- `count`  output  WIDTH  current count (registered)
- `busy`  output  1  1 while in RUN
- `done`  output  1  1 while in DONE
- `tc`  output  1  one-cycle registered pulse when the count reaches 0

## Operation
- Internal registers: `count`, `reload_reg` (WIDTH), a 2-bit state (IDLE, RUN, DONE), and `tc`.
- Priority order, highest first: `reset`, then `load`, then the state-specific action.
- `load`=1, in any state:
  - `count` and `reload_reg` take `load_val`.
  - State goes to IDLE.
  - `tc` is 0 that cycle.
  - A simultaneous `start` or `ack` is ignored.
- IDLE:
  - `start`=1 with `count`≠0 moves to RUN.
  - `start`=1 with `count`=0 moves directly to DONE and pulses `tc`.
  - `hold` and `ack` are ignored.
- RUN:
  - With `hold`=0, `count` decrements by 1 each cycle.
  - The decrement that takes 1 to 0 also moves the state to DONE and sets `tc`=1 for that cycle.
  - With `hold`=1, `count` and state are frozen and `tc`=0.
- DONE:
  - `count` holds at 0.
  - `ack`=1 moves to IDLE. `count` stays 0, so a restart requires `load` first.
  - `start` is ignored.
- Arithmetic is unsigned modulo 2^WIDTH. The count never underflows: a decrement is never applied at 0.
- `busy` and `done` decode the state register directly and are mutually exclusive.

## Timing
- Reset (`reset`=0) asynchronously sets:
  - `count`=0, `reload_reg`=0, state IDLE.
  - `busy`=0, `done`=0, `tc`=0.
- Load latency: `count` shows `load_val` after the edge that samples `load`.
- Countdown latency for load N≥1 and `start` sampled at edge k, with no holds:
  - `busy`=1 after edge k.
  - `count`=N-1 after edge k+1, through `count`=0 after edge k+N.
  - After edge k+N: `tc`=1, `done`=1, `busy`=0.
- Each hold cycle adds one cycle of latency.
- `tc` lasts exactly one cycle per zero crossing.
- `done` stays high until the edge that samples `ack`=1 (or `load`=1). It drops after that edge.
- Reset mid-countdown aborts immediately: no `tc`, no `done`.

## Configuration
- Macro: `DOWN_COUNTER_TIMER_AUTO_RELOAD_EN`.
- Undefined (default): behaviour exactly as above (one-shot).
- Defined (periodic mode), changes in RUN:
  - The enabled cycle after `count` reaches 0 reloads `count` from `reload_reg` instead of entering DONE.
  - `tc` still pulses on every 1→0 decrement, giving a period of N+1 cycles.
  - State stays RUN and `done` never asserts from RUN.
  - The countdown stops only via `load` or `reset`.
- Defined, with `reload_reg`=0: `start` goes to DONE exactly as in one-shot mode.

## Test plan
- Reset, load 5, start, no hold → `count` 4,3,2,1,0 on successive cycles; `tc`=1 and `done`=1 five cycles after start; `ack` → IDLE with `count`=0.
- Load 3, start, `hold` high for 2 cycles after the first decrement → `count` sequence 2,2,2,1,0; `done` 5 cycles after start.
- Load 0, start → DONE and `tc` pulse one cycle after start; `start` while in DONE is ignored; `load` plus `start` in the same cycle → IDLE with `count`=`load_val`.
- Load 200, start, assert `reset`=0 at count 150 → all outputs 0 immediately, no `tc`; load 10 mid-RUN → IDLE with `count`=10, `busy`=0.
- Load 255, start → 255 cycles to `done`, no wrap past 0, `count` holds 0 for 20 idle cycles without `ack`.
- With `DOWN_COUNTER_TIMER_AUTO_RELOAD_EN`: load 2, start → `count` 1,0,2,1,0,2…; `tc` every 3 cycles; `done` stays 0; `load` stops the countdown.

Source files
------------

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - loadable one-shot / periodic down-counting timer
//
// Purpose: load a start value, start, decrement once per non-held cycle down
// to zero, pulse tc on the 1->0 step and hold done until acknowledged.
// Optional periodic mode: define DOWN_COUNTER_TIMER_AUTO_RELOAD_EN.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset
//   load      in   load value and abort to IDLE (overrides start/ack)
//   load_val  in   start and reload value, sampled when load=1
//   start     in   begin countdown, honoured only in IDLE
//   hold      in   freeze count while in RUN
//   ack       in   acknowledge done, honoured only in DONE
//   count     out  current count (registered)
//   busy      out  1 while in RUN
//   done      out  1 while in DONE
//   tc        out  one-cycle registered pulse on reaching zero

module down_counter_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             hold,
    input  logic             ack,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             tc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             tc_q, tc_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            state_d  = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (count_q != ZERO) begin
                            state_d = ST_RUN;
                        end else begin
                            // Zero-length interval: expire immediately.
                            state_d = ST_DONE;
                            tc_d    = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (!hold) begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                        // Periodic: the cycle spent at zero reloads, so the
                        // period is N+1 cycles and RUN is never left here.
                        if (count_q == ZERO) begin
                            count_d = reload_q;
                        end else begin
                            count_d = count_q - ONE;
                            tc_d    = (count_q == ONE);
                        end
`else
                        if (count_q == ZERO) begin
                            // Unreachable in normal use; never decrement at 0.
                            state_d = ST_DONE;
                        end else begin
                            count_d = count_q - ONE;
                            if (count_q == ONE) begin
                                state_d = ST_DONE;
                                tc_d    = 1'b1;
                            end
                        end
`endif
                    end
                end
                ST_DONE: begin
                    count_d = ZERO;
                    if (ack) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign count = count_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = (state_q == ST_DONE);
    assign tc    = tc_q;

endmodule
